pc_seq_unit: RTL
================

# pc_seq_unit

Parametrised program-counter sequencer for the MIPS core, replacing the single-width PC register. It holds the fetch PC and advances it under a fetch valid/ready handshake. It resolves branch, jump, register-jump, exception and exception-return redirects by fixed priority. It also keeps a circular return-address stack (RAS) that supplies return targets for `jal`/`jr $ra` pairs.

## Interface
- `ADDR_W`, 32: PC width; must be at least 30.
- `RESET_VEC`, 32'h0000_3000: PC value loaded at reset.
- `EXC_VEC`, 32'h0000_4180: exception entry address.
- `RAS_DEPTH`, 4: number of RAS entries; a power of two, 2 to 16.

Ports:
- `Clk`  in  1  rising-edge clock.
- `PcReSetN`  in  1  asynchronous, active-low reset.
- `FetchReady`  in  1  fetch stage accepts the current `PC` this cycle.
- `PcSel`  in  1  conditional branch taken.
- `BrOffset`  in  ADDR_W  sign-extended word offset.
- `JumpEn`  in  1  `j`/`jal`.
- `JumpTarget`  in  26  instruction index field.
- `JrEn`  in  1  `jr`/`jalr`.
- `JrTarget`  in  ADDR_W  register target.
- `LinkEn`  in  1  push PC+4 onto the RAS (`jal`/`jalr`).
- `RetEn`  in  1  predicted return; pops the RAS.
- `ExcEn`  in  1  exception request.
- `EretEn`  in  1  `eret`.
- `PC`  out  ADDR_W  current fetch address.
- `FetchValid`  out  1  `PC` is valid for fetch.
- `Epc`  out  ADDR_W  saved exception PC.
- `RasCount`  out  $clog2(RAS_DEPTH)+1  number of RAS entries in use.
- `RasMiss`  out  1  one-cycle pulse when `RetEn` hits an empty RAS.

## Operation

States:
- BOOT: entered on reset.
- RUN: normal fetch.
- EXC_BUBBLE: one dead cycle after exception entry.

State transitions:
- BOOT → RUN on the first `Clk` edge after `PcReSetN` goes high. `PC` holds `RESET_VEC` across that edge.
- RUN → EXC_BUBBLE on `ExcEn`.
- EXC_BUBBLE → RUN unconditionally on the next edge.

`FetchValid` is 1 only in RUN. A "fire" is a RUN cycle with `FetchReady`=1.

On a fire, the next `PC` is chosen by this priority, highest first:
1. `ExcEn`: `Epc` ← `PC`; `PC` ← `EXC_VEC`.
2. `EretEn`: `PC` ← `Epc`.
3. `RetEn`: `PC` ← RAS top if `RasCount`>0. If `RasCount`=0, `PC` ← `JrTarget` and `RasMiss`=1.
4. `JrEn`: `PC` ← `JrTarget`.
5. `JumpEn`: `PC` ← {(PC+4)[ADDR_W-1:28], `JumpTarget`, 2'b00}.
6. `PcSel`: `PC` ← PC + 4 + (`BrOffset` << 2).
7. None of the above: `PC` ← PC + 4.

Control rules:
- `ExcEn` takes effect in RUN even when `FetchReady`=0.
- All other controls are ignored unless the cycle is a fire.
- All controls are ignored in BOOT and EXC_BUBBLE.

Arithmetic:
- All additions wrap modulo 2^ADDR_W.
- Bits [1:0] of every loaded target, including `JrTarget` and `Epc`, are forced to 0.

RAS behaviour:
- Pop only occurs when `RetEn` is the selected action.
- Push occurs whenever `LinkEn`=1 on a fire and `ExcEn` is not asserted. The pushed value is the pre-update PC + 4.
- Pop and push in the same fire: the top entry is replaced; `RasCount` is unchanged.
- Push when full: the oldest entry is overwritten circularly; `RasCount` saturates at `RAS_DEPTH`.
- Pop when empty: `RasCount` stays 0.

Exceptions: `ExcEn` never modifies the RAS. `Epc` changes only on exception entry.

## Timing
- All outputs are registered; each redirect appears on `PC` one edge after the fire.
- Reset values:
  - `PC` = `RESET_VEC`
  - `FetchValid` = 0
  - `Epc` = 0
  - `RasCount` = 0
  - `RasMiss` = 0
  - State = BOOT
- Reset is asynchronous: asserting `PcReSetN` mid-operation clears all state immediately, without waiting for `Clk`.
- Stall: while `FetchReady`=0 in RUN, `PC` is held stable. `FetchValid` stays 1.
- Exception latency: `PC`=`EXC_VEC` one edge after `ExcEn`. `FetchValid` is 0 for that one cycle (EXC_BUBBLE), then returns to 1.
- `RasMiss` is high only during the cycle after the missing pop.

## Test plan
- Reset release, `FetchReady`=1 for 3 cycles → `FetchValid` rises one edge after release; `PC` reads 0x3000, 0x3000, 0x3004, 0x3008.
- At `PC`=0x3010, `PcSel`=1, `BrOffset`=0xFFFF_FFFC → next `PC`=0x3004. At `PC`=0x3000, `JumpEn`, `JumpTarget`=0x0000C40 → next `PC`=0x0000_3100.
- Stall: hold `FetchReady`=0 for 5 cycles while pulsing `JumpEn` → `PC` unchanged. Then `ExcEn` with `FetchReady`=0 at `PC`=0x3020 → `Epc`=0x3020, `PC`=0x4180, one cycle with `FetchValid`=0. `EretEn` → `PC`=0x3020.
- Five `jal` fires (`LinkEn`+`JumpEn`) from 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 with `RAS_DEPTH`=4 → `RasCount`=4. Four `RetEn` fires return 0x3404, 0x3304, 0x3204, 0x3104. A fifth `RetEn` with `JrTarget`=0x3abc → `PC`=0x3abc, `RasMiss` pulses.
- `RetEn`+`LinkEn` together with `RasCount`=2 → `RasCount` stays 2; the new top is the pushed PC+4.
- Assert `PcReSetN`=0 asynchronously between clock edges mid-stall → `PC`=0x3000 and `FetchValid`=0 immediately, `RasCount`=0.

Source files
------------

// File: rtl/pc_seq_unit.sv
// Fetch program-counter sequencer: boot/run/exception-bubble FSM, prioritised
// redirects and a circular return-address stack for jal / jr $ra pairs.
module pc_seq_unit #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_4180),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         PcReSetN,
  input  logic                         FetchReady,
  input  logic                         PcSel,
  input  logic [ADDR_W-1:0]            BrOffset,
  input  logic                         JumpEn,
  input  logic [25:0]                  JumpTarget,
  input  logic                         JrEn,
  input  logic [ADDR_W-1:0]            JrTarget,
  input  logic                         LinkEn,
  input  logic                         RetEn,
  input  logic                         ExcEn,
  input  logic                         EretEn,
  output logic [ADDR_W-1:0]            PC,
  output logic                         FetchValid,
  output logic [ADDR_W-1:0]            Epc,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic                         RasMiss
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [1:0] {BOOT, RUN, EXC_BUBBLE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_epc, w_epc_nxt;
  logic              r_fv, r_miss, w_miss;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_top, w_top_inc, w_top_dec;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic              w_push, w_pop;
  logic [ADDR_W-1:0] w_pc4;

  assign w_pc4     = r_pc + ADDR_W'(4);
  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      BOOT:       w_state_nxt = RUN;
      EXC_BUBBLE: w_state_nxt = RUN;
      RUN: begin
        // Exceptions are taken even on a stalled cycle.
        if (ExcEn) begin
          w_state_nxt = EXC_BUBBLE;
          w_epc_nxt   = r_pc & ALIGN;
          w_pc_nxt    = EXC_VEC & ALIGN;
        end else if (FetchReady) begin
          w_push = LinkEn;
          if (EretEn)
            w_pc_nxt = r_epc & ALIGN;
          else if (RetEn) begin
            if (r_cnt != '0) begin
              w_pc_nxt = r_ras[r_top];
              w_pop    = 1'b1;
            end else begin
              w_pc_nxt = JrTarget & ALIGN;
              w_miss   = 1'b1;
            end
          end
          else if (JrEn)   w_pc_nxt = JrTarget & ALIGN;
          else if (JumpEn) w_pc_nxt = {w_pc4[ADDR_W-1:28], JumpTarget, 2'b00};
          else if (PcSel)  w_pc_nxt = w_pc4 + (BrOffset << 2);
          else             w_pc_nxt = w_pc4;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge PcReSetN) begin
    if (!PcReSetN) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC;
      r_epc   <= '0;
      r_fv    <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_fv    <= (w_state_nxt == RUN);
      r_miss  <= w_miss;
    end
  end

  // Circular stack: a push on a full stack silently overwrites the oldest slot.
  always_ff @(posedge Clk or negedge PcReSetN) begin
    if (!PcReSetN) begin
      r_cnt <= '0;
      r_top <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (w_push && w_pop) begin
      r_ras[r_top] <= w_pc4;
    end else if (w_push) begin
      r_top            <= w_top_inc;
      r_ras[w_top_inc] <= w_pc4;
      if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_top <= w_top_dec;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign PC         = r_pc;
  assign FetchValid = r_fv;
  assign Epc        = r_epc;
  assign RasCount   = r_cnt;
  assign RasMiss    = r_miss;

endmodule
